// File: rtl/mic_array_delay_sum.sv
// mic_array_delay_sum: N-channel delay-and-sum / solo stage over per-channel circular buffers
// Ports:
//   audio_clk, rst_in (sync, active-low)
//   sample_valid_in  1-cycle strobe, new sample set
//   audio_in         NUM_CH signed samples, ch k at [k*SAMPLE_W +: SAMPLE_W]
//   delay_in         per-channel delay in samples, ch k at [k*DELAY_W +: DELAY_W]
//   shift_in         arithmetic right shift applied to the sum
//   mode_in          0 = delay-and-sum, 1 = solo channel
//   solo_ch_in       channel soloed in solo mode (>= NUM_CH gives 0)
//   audio_out        signed result, held until next valid
//   audio_valid_out  1-cycle strobe when audio_out updates
//   busy_out         high from accept through the valid cycle
//   overrun_out      sticky: strobe arrived while busy
module mic_array_delay_sum #(
    parameter int NUM_CH   = 3,
    parameter int SAMPLE_W = 16,
    parameter int DEPTH    = 256,
    parameter int DELAY_W  = 8
) (
    input  logic                         audio_clk,
    input  logic                         rst_in,
    input  logic                         sample_valid_in,
    input  logic [NUM_CH*SAMPLE_W-1:0]   audio_in,
    input  logic [NUM_CH*DELAY_W-1:0]    delay_in,
    input  logic [3:0]                   shift_in,
    input  logic                         mode_in,
    input  logic [$clog2(NUM_CH):0]      solo_ch_in,
    output logic signed [SAMPLE_W-1:0]   audio_out,
    output logic                         audio_valid_out,
    output logic                         busy_out,
    output logic                         overrun_out
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CH_W  = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
    localparam int CNT_W = $clog2(NUM_CH + 2) + 1;
    localparam int ACC_W = SAMPLE_W + $clog2(NUM_CH) + 1;
    localparam int XW    = (DELAY_W > PTR_W ? DELAY_W : PTR_W) + 1;
    localparam logic signed [ACC_W-1:0] MAXV = {{(ACC_W-SAMPLE_W+1){1'b0}}, {(SAMPLE_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] MINV = ~MAXV;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, OUT} state_t;

    state_t                      state;
    logic [CNT_W-1:0]            cnt;
    logic [PTR_W-1:0]            wr_ptr;
    logic [PTR_W:0]              fill;
    logic signed [SAMPLE_W-1:0]  lat_x [NUM_CH];
    logic [PTR_W-1:0]            lat_d [NUM_CH];
    logic [3:0]                  lat_shift;
    logic                        lat_mode;
    logic [$clog2(NUM_CH):0]     lat_solo;
    logic signed [ACC_W-1:0]     acc;
    logic signed [SAMPLE_W-1:0]  solo_r;
    logic [SAMPLE_W-1:0]         mem [NUM_CH*DEPTH];
    logic [SAMPLE_W-1:0]         q1, q2;

    function automatic logic [PTR_W-1:0] clamp(input logic [DELAY_W-1:0] v);
        logic [XW-1:0] x;
        x = XW'(v);
        return x > XW'(DEPTH - 1) ? PTR_W'(DEPTH - 1) : x[PTR_W-1:0];
    endfunction

    // cnt steps once per cycle from T+1; channel cnt is issued, channel cnt-2 returns
    logic [CH_W-1:0]            wch, rch;
    logic [CNT_W-1:0]           rcnt;
    logic [PTR_W-1:0]           rd_ptr;
    logic                       ret, last;
    logic signed [SAMPLE_W-1:0] y, solo_fin, sat_out;
    logic signed [ACC_W-1:0]    acc_fin, shifted;

    assign wch      = cnt[CH_W-1:0];
    assign rcnt     = cnt - CNT_W'(2);
    assign rch      = rcnt[CH_W-1:0];
    assign rd_ptr   = wr_ptr - lat_d[wch];
    assign ret      = (state == RUN || state == DRAIN) && cnt >= CNT_W'(2);
    assign last     = state == DRAIN && cnt == CNT_W'(NUM_CH + 1);
    // zero delay bypasses the RAM; delays reaching past the fill level read as silence
    assign y        = lat_d[rch] == '0 ? lat_x[rch] :
                      (PTR_W+1)'(lat_d[rch]) > fill ? '0 : $signed(q2);
    assign acc_fin  = acc + ACC_W'(y);
    assign shifted  = acc_fin >>> lat_shift;
    assign sat_out  = shifted > MAXV ? MAXV[SAMPLE_W-1:0] :
                      shifted < MINV ? MINV[SAMPLE_W-1:0] : shifted[SAMPLE_W-1:0];
    assign solo_fin = CNT_W'(lat_solo) == rcnt ? y : solo_r;

    // dual-port RAM, two-cycle read (array read register + output register)
    always_ff @(posedge audio_clk) begin
        if (state == RUN) mem[{wch, wr_ptr}] <= lat_x[wch];
        q1 <= mem[{wch, rd_ptr}];
        q2 <= q1;
    end

    always_ff @(posedge audio_clk) begin
        if (!rst_in) begin
            state           <= IDLE;
            cnt             <= '0;
            wr_ptr          <= '0;
            fill            <= '0;
            acc             <= '0;
            solo_r          <= '0;
            audio_out       <= '0;
            audio_valid_out <= 1'b0;
            busy_out        <= 1'b0;
            overrun_out     <= 1'b0;
        end else begin
            audio_valid_out <= 1'b0;
            if (sample_valid_in && busy_out) overrun_out <= 1'b1;
            if (ret) begin
                acc <= acc_fin;
                if (CNT_W'(lat_solo) == rcnt) solo_r <= y;
            end
            case (state)
                IDLE: if (sample_valid_in) begin
                    for (int k = 0; k < NUM_CH; k++) begin
                        lat_x[k] <= audio_in[k*SAMPLE_W +: SAMPLE_W];
                        lat_d[k] <= clamp(delay_in[k*DELAY_W +: DELAY_W]);
                    end
                    lat_shift <= shift_in;
                    lat_mode  <= mode_in;
                    lat_solo  <= solo_ch_in;
                    acc       <= '0;
                    solo_r    <= '0;
                    cnt       <= '0;
                    busy_out  <= 1'b1;
                    state     <= RUN;
                end
                RUN: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(NUM_CH - 1)) state <= DRAIN;
                end
                DRAIN: begin
                    cnt <= cnt + 1'b1;
                    if (last) begin
                        audio_out       <= lat_mode ? solo_fin : sat_out;
                        audio_valid_out <= 1'b1;
                        state           <= OUT;
                    end
                end
                OUT: begin
                    wr_ptr   <= wr_ptr + 1'b1;
                    fill     <= fill == (PTR_W+1)'(DEPTH) ? fill : fill + 1'b1;
                    busy_out <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mic_array_delay_sum.sv
// tb_mic_array_delay_sum: randomized bench against a sample-history reference model
module tb_mic_array_delay_sum;
    localparam int NCH = 3, SW = 16, DEPTH = 256, DW = 9;

    logic                  clk = 1'b0, rst_n = 1'b0, sv = 1'b0;
    logic [NCH*SW-1:0]     ain = '0;
    logic [NCH*DW-1:0]     din = '0;
    logic [3:0]            sh = '0;
    logic                  md = 1'b0;
    logic [2:0]            solo = '0;
    logic signed [SW-1:0]  aout;
    logic                  aval, busy, ovr;

    int checks = 0, failures = 0;
    int hist [NCH][1024];
    int n = 0;

    always #5 clk = ~clk;

    mic_array_delay_sum #(.NUM_CH(NCH), .SAMPLE_W(SW), .DEPTH(DEPTH), .DELAY_W(DW)) dut (
        .audio_clk(clk), .rst_in(rst_n), .sample_valid_in(sv), .audio_in(ain),
        .delay_in(din), .shift_in(sh), .mode_in(md), .solo_ch_in(solo),
        .audio_out(aout), .audio_valid_out(aval), .busy_out(busy), .overrun_out(ovr)
    );

    task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // reference: y_k[n] = x_k[n-d_k] taken from the full history since reset
    task automatic model_push(input int x0, x1, x2, d0, d1, d2, s, m, so, output int e);
        int x[3], dl[3], y[3], sum, d;
        x = '{x0, x1, x2};
        dl = '{d0, d1, d2};
        sum = 0;
        for (int k = 0; k < NCH; k++) begin
            hist[k][n] = x[k];
            d = dl[k] > DEPTH - 1 ? DEPTH - 1 : dl[k];
            y[k] = d == 0 ? x[k] : d > n ? 0 : hist[k][n-d];
            sum += y[k];
        end
        sum = sum >>> s;
        e = m != 0 ? (so < NCH ? y[so] : 0) : sum > 32767 ? 32767 : sum < -32768 ? -32768 : sum;
        n++;
    endtask

    task automatic drive(input int x0, x1, x2, d0, d1, d2, s, m, so);
        ain  = {16'(x2), 16'(x1), 16'(x0)};
        din  = {9'(d2), 9'(d1), 9'(d0)};
        sh   = 4'(s);
        md   = 1'(m);
        solo = 3'(so);
        sv   = 1'b1;
    endtask

    task automatic scramble();
        sv   = 1'b0;
        ain  = {$urandom, $urandom};
        din  = 27'($urandom);
        sh   = 4'($urandom);
        md   = 1'($urandom);
        solo = 3'($urandom);
    endtask

    task automatic send(input int x0, x1, x2, d0, d1, d2, s, m, so, input bit tim, output int got);
        int e, lat, bc;
        model_push(x0, x1, x2, d0, d1, d2, s, m, so, e);
        @(negedge clk);
        drive(x0, x1, x2, d0, d1, d2, s, m, so);
        lat = 0;
        bc = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            scramble();
            if (busy) bc++;
            if (aval) begin
                lat = i;
                break;
            end
        end
        if (tim) begin
            check("latency", lat, 6);
            check("busy_cycles", bc, 6);
        end else if (lat == 0) check("valid_timeout", lat, 6);
        got = int'(aout);
        check("audio_out", got, e);
    endtask

    function automatic int rs16();
        return int'($urandom_range(65535)) - 32768;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int got, e, seen, pos;
        repeat (3) @(negedge clk);
        check("rst_audio_out", aout, 0);
        check("rst_valid", aval, 0);
        check("rst_busy", busy, 0);
        check("rst_overrun", ovr, 0);
        rst_n = 1'b1;
        n = 0;

        // zero delay sum
        send(1000, 2000, -500, 0, 0, 0, 0, 0, 0, 1, got);
        check("zero_delay_sum", got, 2500);

        // overrun: second strobe at T+3, then a strobe in the OUT cycle
        model_push(111, 222, 333, 0, 0, 1, 0, 0, 0, e);
        @(negedge clk); drive(111, 222, 333, 0, 0, 1, 0, 0, 0);
        @(negedge clk); scramble();
        @(negedge clk);
        @(negedge clk); drive(9999, 9999, 9999, 0, 0, 0, 0, 0, 0);
        pos = 0;
        for (int i = 4; i <= 20; i++) begin
            @(negedge clk);
            scramble();
            if (aval) begin
                pos = i;
                break;
            end
        end
        check("ovr_latency", pos, 6);
        check("ovr_result", aout, e);
        check("ovr_flag", ovr, 1);
        drive(5, 5, 5, 0, 0, 0, 0, 0, 0);
        @(negedge clk); scramble();
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (aval) seen++;
        end
        check("out_cycle_drop", seen, 0);
        check("idle_busy", busy, 0);

        // saturation and shift
        send(32767, 32767, 32767, 0, 0, 0, 0, 0, 0, 1, got);
        check("sat_pos", got, 32767);
        send(-32768, -32768, -32768, 0, 0, 0, 0, 0, 0, 1, got);
        check("sat_neg", got, -32768);
        send(30000, 30000, 30000, 0, 0, 0, 2, 0, 0, 1, got);
        check("shift2", got, 22500);
        check("ovr_held", ovr, 1);

        // reset in the middle of an operation
        @(negedge clk); drive(100, 200, 300, 0, 0, 0, 0, 0, 0);
        @(negedge clk); scramble();
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        n = 0;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (aval) seen++;
        end
        check("midrst_no_valid", seen, 0);
        check("midrst_out", aout, 0);
        check("midrst_busy", busy, 0);
        check("midrst_ovr", ovr, 0);
        send(7, 8, 9, 1, 2, 0, 0, 0, 0, 1, got);
        check("after_rst_fill0", got, 9);

        // impulse on ch0, delay 5, solo ch0
        pos = -1;
        for (int i = 0; i < 10; i++) begin
            send(i == 0 ? 16'h4000 : 0, rs16(), rs16(), 5, $urandom_range(3), 0, 0, 1, 0, 1, got);
            if (got == 16'h4000) pos = i;
        end
        check("impulse_pos", pos, 5);

        // random mix
        for (int i = 0; i < 40; i++)
            send(rs16(), rs16(), rs16(),
                 $urandom_range(3) == 0 ? 0 : $urandom_range(40),
                 $urandom_range(3) == 0 ? 0 : $urandom_range(40),
                 $urandom_range(7) == 0 ? 300 : $urandom_range(40),
                 $urandom_range(6), $urandom_range(1), $urandom_range(3), 1, got);

        // ramp with delay 200 across pointer wrap, soloing each channel in turn
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        n = 0;
        for (int i = 0; i < 600; i++)
            send(((i*97) % 65536) - 32768, ((i*97 + 5000) % 65536) - 32768,
                 ((i*97 + 10000) % 65536) - 32768, 200, 200, 200, 0, 1, i % 3, 0, got);

        // delay 300 clamps to 255
        for (int i = 0; i < 6; i++) begin
            send(rs16(), rs16(), rs16(), 300, 255, 300, 0, 1, 0, 1, got);
            check("clamp_255", got, hist[0][n-1-255]);
        end
        send(rs16(), rs16(), rs16(), 255, 300, 17, 1, 0, 0, 1, got);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
